// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the alu_seq sequential ALU.
//   state_t        : FSM state encoding (visible on curr_state/next_state)
//   OP_*           : bit positions inside the one-hot op_sel bus
//   IN_*           : bit positions inside the in_sel operand-control bus
//   is_onehot()    : legality test for op_sel
package alu_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_IDLE = 2'b01,
    ST_EXEC = 2'b10,
    ST_MULT = 2'b11
  } state_t;

  localparam int OP_W   = 7;
  localparam int OP_ADD = 6;
  localparam int OP_SUB = 5;
  localparam int OP_AND = 4;
  localparam int OP_OR  = 3;
  localparam int OP_XOR = 2;
  localparam int OP_NOT = 1;
  localparam int OP_MUL = 0;

  localparam int IN_W       = 3;
  localparam int IN_PERSIST = 2;
  localparam int IN_LOAD    = 1;
  localparam int IN_CLEAR   = 0;

  // Exactly one bit set; an all-zero vector is not one-hot.
  function automatic logic is_onehot(input logic [OP_W-1:0] v);
    return (v != '0) && ((v & (v - OP_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul -- shift-add unsigned multiplier, one multiplier bit per cycle.
//   clk, rst   : clock, synchronous active-high reset
//   start      : load a/b and begin (ignored unless issued by the owner FSM)
//   abort      : drop an in-flight product and clear all partials
//   a, b       : WIDTH-bit unsigned operands
//   done       : combinational, high in the cycle whose edge retires bit WIDTH-1
//   product    : 2*WIDTH-bit result, valid while done is high
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic                 active;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     mplier;

  // The partial for the current bit is folded in combinationally so the
  // finished product is available on the same edge that retires the last bit.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign done     = active && (cnt == CNT_LAST);
  assign product  = acc_next;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      active <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (active) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        active <= 1'b0;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq -- sequential ALU with accumulator, one-hot op select and a
// multi-cycle shift-add multiply.
//   clk, rst            : clock, synchronous active-high reset
//   on                  : block enable; low forces OFF and aborts any operation
//   start               : request, only honoured in IDLE
//   in_sel              : {persist, load, clear} operand control
//   num1, num2          : operands (A from num1 or the accumulator, B = num2)
//   op_sel              : one-hot {ADD,SUB,AND,OR,XOR,NOT,MUL}
//   out, out_hi         : registered result / accumulator, MUL high half
//   done                : one-cycle completion pulse
//   busy                : high in EXEC or MULT
//   err,carry,zero,ovf  : registered status, updated only with done
//   curr_state          : registered FSM state
//   next_state          : combinational next state
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              on,
  input  logic              start,
  input  logic [IN_W-1:0]   in_sel,
  input  logic [WIDTH-1:0]  num1,
  input  logic [WIDTH-1:0]  num2,
  input  logic [OP_W-1:0]   op_sel,
  output logic [WIDTH-1:0]  out,
  output logic [WIDTH-1:0]  out_hi,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic              carry,
  output logic              zero,
  output logic              ovf,
  output logic [1:0]        curr_state,
  output logic [1:0]        next_state
);

  state_t              state_q;
  state_t              state_d;

  logic [WIDTH-1:0]    opa_q;
  logic [WIDTH-1:0]    opb_q;
  logic [OP_W-1:0]     op_q;
  logic                clr_q;

  logic [WIDTH-1:0]    a_sel;
  logic                go;
  logic                go_mul;
  logic                unused_load;

  logic                mul_done;
  logic [2*WIDTH-1:0]  mul_prod;

  logic [WIDTH:0]      sum;
  logic [WIDTH:0]      diff;
  logic [WIDTH-1:0]    exec_res;
  logic                exec_carry;
  logic                exec_ovf;

  // Signed-overflow detection: operands and result viewed as two's complement.
  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] r);
    return ((a < 0) == (b < 0)) && ((r < 0) != (a < 0));
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] r);
    return ((a < 0) != (b < 0)) && ((r < 0) != (a < 0));
  endfunction

  // A comes from the accumulator when persist is set; otherwise num1 is used,
  // which covers both an explicit load and the all-zero in_sel code, so the
  // load bit itself carries no extra information.
  assign a_sel       = in_sel[IN_PERSIST] ? out : num1;
  assign unused_load = in_sel[IN_LOAD];

  assign go     = on && start && (state_q == ST_IDLE);
  // Clear outranks the op, so a cleared MUL takes the single-cycle EXEC path.
  assign go_mul = go && !in_sel[IN_CLEAR] && is_onehot(op_sel) && op_sel[OP_MUL];

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (go_mul),
    .abort   (!on),
    .a       (a_sel),
    .b       (num2),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    state_d = state_q;
    if (!on) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:  state_d = ST_IDLE;
        ST_IDLE: if (start) state_d = go_mul ? ST_MULT : ST_EXEC;
        ST_EXEC: state_d = ST_IDLE;
        ST_MULT: if (mul_done) state_d = ST_IDLE;
        default: state_d = ST_OFF;
      endcase
    end
  end

  assign curr_state = state_q;
  assign next_state = state_d;
  assign busy       = (state_q == ST_EXEC) || (state_q == ST_MULT);

  // Single-cycle datapath, evaluated from the operands latched at start.
  always_comb begin
    sum        = {1'b0, opa_q} + {1'b0, opb_q};
    diff       = {1'b0, opa_q} - {1'b0, opb_q};
    exec_res   = '0;
    exec_carry = 1'b0;
    exec_ovf   = 1'b0;
    if (op_q[OP_ADD]) begin
      exec_res   = sum[WIDTH-1:0];
      exec_carry = sum[WIDTH];
      exec_ovf   = add_ovf(opa_q, opb_q, sum[WIDTH-1:0]);
    end else if (op_q[OP_SUB]) begin
      exec_res   = diff[WIDTH-1:0];
      exec_carry = diff[WIDTH];          // borrow: A < B unsigned
      exec_ovf   = sub_ovf(opa_q, opb_q, diff[WIDTH-1:0]);
    end else if (op_q[OP_AND]) begin
      exec_res = opa_q & opb_q;
    end else if (op_q[OP_OR]) begin
      exec_res = opa_q | opb_q;
    end else if (op_q[OP_XOR]) begin
      exec_res = opa_q ^ opb_q;
    end else if (op_q[OP_NOT]) begin
      exec_res = ~opa_q;
    end
  end

  // Operand capture: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (go) begin
      opa_q <= a_sel;
      opb_q <= num2;
      op_q  <= op_sel;
      clr_q <= in_sel[IN_CLEAR];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      out     <= '0;
      out_hi  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      if (on && (state_q == ST_EXEC)) begin
        done <= 1'b1;
        if (clr_q) begin
          out    <= '0;
          out_hi <= '0;
          err    <= 1'b0;
          carry  <= 1'b0;
          zero   <= 1'b1;
          ovf    <= 1'b0;
        end else if (!is_onehot(op_q)) begin
          // Illegal op: flag it, leave result and other status untouched.
          err <= 1'b1;
        end else begin
          out    <= exec_res;
          out_hi <= '0;
          err    <= 1'b0;
          carry  <= exec_carry;
          zero   <= (exec_res == '0);
          ovf    <= exec_ovf;
        end
      end else if (on && (state_q == ST_MULT) && mul_done) begin
        done   <= 1'b1;
        out    <= mul_prod[WIDTH-1:0];
        out_hi <= mul_prod[2*WIDTH-1:WIDTH];
        err    <= 1'b0;
        carry  <= 1'b0;
        zero   <= (mul_prod == '0);
        ovf    <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int W = 8;
  localparam logic [6:0] ADD = 7'b1000000;
  localparam logic [6:0] SUB = 7'b0100000;
  localparam logic [6:0] AND = 7'b0010000;
  localparam logic [6:0] OR  = 7'b0001000;
  localparam logic [6:0] XOR = 7'b0000100;
  localparam logic [6:0] NOT = 7'b0000010;
  localparam logic [6:0] MUL = 7'b0000001;

  logic clk = 1'b0;
  logic rst, on, start;
  logic [2:0] in_sel;
  logic [W-1:0] num1, num2;
  logic [6:0] op_sel;
  logic [W-1:0] out, out_hi;
  logic done, busy, err, carry, zero, ovf;
  logic [1:0] curr_state, next_state;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .on(on), .start(start), .in_sel(in_sel),
    .num1(num1), .num2(num2), .op_sel(op_sel), .out(out), .out_hi(out_hi),
    .done(done), .busy(busy), .err(err), .carry(carry), .zero(zero),
    .ovf(ovf), .curr_state(curr_state), .next_state(next_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]   insel;
    logic [W-1:0] n1, n2;
    logic [6:0]   op;
    logic [W-1:0] eout, ehi;
    logic         eerr, ec, ez, ev;
    int           lat;
  } vec_t;

  vec_t tbl [22];

  // Reference state: what the accumulator and status should hold.
  logic [W-1:0] m_out, m_hi;
  logic         m_err, m_c, m_z, m_v;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] s, input int a, input int b, input logic [6:0] op,
                              input int eo, input int eh, input logic er, input logic c,
                              input logic z, input logic v, input int lat);
    vec_t r;
    r.insel = s; r.n1 = W'(a); r.n2 = W'(b); r.op = op;
    r.eout = W'(eo); r.ehi = W'(eh); r.eerr = er; r.ec = c; r.ez = z; r.ev = v; r.lat = lat;
    return r;
  endfunction

  // Behavioural model: plain integer arithmetic on the operation rules.
  task automatic model_step(input logic [2:0] s, input logic [W-1:0] n1, input logic [W-1:0] n2,
                            input logic [6:0] op, output int lat);
    int a, b, sa, sb, r;
    longint p;
    a  = s[2] ? int'(m_out) : int'(n1);
    b  = int'(n2);
    sa = (a >= 2**(W-1)) ? a - 2**W : a;
    sb = (b >= 2**(W-1)) ? b - 2**W : b;
    lat = 1;
    if (s[0]) begin
      m_out = '0; m_hi = '0; m_err = 0; m_c = 0; m_z = 1; m_v = 0;
    end else if ($countones(op) != 1) begin
      m_err = 1;
    end else begin
      m_err = 0; m_hi = '0; m_c = 0; m_v = 0;
      if (op == ADD) begin
        r = a + b; m_out = W'(r); m_c = (r >= 2**W);
        m_v = ((sa + sb) > 2**(W-1) - 1) || ((sa + sb) < -(2**(W-1)));
      end else if (op == SUB) begin
        r = a - b; m_out = W'(r); m_c = (a < b);
        m_v = ((sa - sb) > 2**(W-1) - 1) || ((sa - sb) < -(2**(W-1)));
      end else if (op == AND) m_out = W'(a & b);
      else if (op == OR)      m_out = W'(a | b);
      else if (op == XOR)     m_out = W'(a ^ b);
      else if (op == NOT)     m_out = W'(~a);
      if (op == MUL) begin
        p = longint'(a) * longint'(b);
        m_out = W'(p); m_hi = W'(p >> W); m_v = (m_hi != 0); m_z = (p == 0);
        lat = W;
      end else begin
        m_z = (m_out == 0);
      end
    end
  endtask

  // Issue one request from IDLE and wait (bounded) for done; lat = -1 on timeout.
  task automatic run_op(input logic [2:0] s, input logic [W-1:0] n1, input logic [W-1:0] n2,
                        input logic [6:0] op, output int lat);
    in_sel = s; num1 = n1; num2 = n2; op_sel = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic model_op(input string tag, input logic [2:0] s, input logic [W-1:0] n1,
                          input logic [W-1:0] n2, input logic [6:0] op);
    int elat, lat;
    model_step(s, n1, n2, op, elat);
    run_op(s, n1, n2, op, lat);
    check({tag, " latency"}, lat, elat);
    check({tag, " out"}, out, m_out);
    check({tag, " out_hi"}, out_hi, m_hi);
    check({tag, " err"}, err, m_err);
    check({tag, " carry"}, carry, m_c);
    check({tag, " zero"}, zero, m_z);
    check({tag, " ovf"}, ovf, m_v);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual running, required finished");
    $fatal(1, "simulation timed out");
  end

  initial begin
    int lat, cyc;
    bit seen;
    logic [2:0] s;
    logic [6:0] op;
    int rsel;

    tbl[0]  = mk(3'b010, 87, 26, ADD, 113, 0, 0, 0, 0, 0, 1);
    tbl[1]  = mk(3'b010, 87, 26, SUB, 61, 0, 0, 0, 0, 0, 1);
    tbl[2]  = mk(3'b010, 87, 26, AND, 18, 0, 0, 0, 0, 0, 1);
    tbl[3]  = mk(3'b010, 87, 26, OR,  95, 0, 0, 0, 0, 0, 1);
    tbl[4]  = mk(3'b010, 87, 26, XOR, 77, 0, 0, 0, 0, 0, 1);
    tbl[5]  = mk(3'b010, 87, 26, NOT, 168, 0, 0, 0, 0, 0, 1);
    tbl[6]  = mk(3'b010, 87, 26, MUL, 214, 8, 0, 0, 0, 1, 8);
    tbl[7]  = mk(3'b010, 87, 26, ADD, 113, 0, 0, 0, 0, 0, 1);
    tbl[8]  = mk(3'b100, 5, 113, SUB, 0, 0, 0, 0, 1, 0, 1);
    tbl[9]  = mk(3'b001, 9, 9, ADD, 0, 0, 0, 0, 1, 0, 1);
    tbl[10] = mk(3'b010, 1, 2, 7'b0000011, 0, 0, 1, 0, 1, 0, 1);
    tbl[11] = mk(3'b010, 1, 2, 7'b0000000, 0, 0, 1, 0, 1, 0, 1);
    tbl[12] = mk(3'b010, 255, 1, ADD, 0, 0, 0, 1, 1, 0, 1);
    tbl[13] = mk(3'b010, 127, 1, ADD, 128, 0, 0, 0, 0, 1, 1);
    tbl[14] = mk(3'b010, 0, 1, SUB, 255, 0, 0, 1, 0, 0, 1);
    tbl[15] = mk(3'b010, 128, 1, SUB, 127, 0, 0, 0, 0, 1, 1);
    tbl[16] = mk(3'b010, 255, 255, MUL, 1, 254, 0, 0, 0, 1, 8);
    tbl[17] = mk(3'b010, 3, 4, 7'b0000000, 1, 254, 1, 0, 0, 1, 1);
    tbl[18] = mk(3'b010, 0, 77, MUL, 0, 0, 0, 0, 1, 0, 8);
    tbl[19] = mk(3'b000, 10, 20, ADD, 30, 0, 0, 0, 0, 0, 1);
    tbl[20] = mk(3'b100, 0, 3, MUL, 90, 0, 0, 0, 0, 0, 8);
    tbl[21] = mk(3'b001, 7, 7, MUL, 0, 0, 0, 0, 1, 0, 1);

    // Reset with on already high: rst wins, then OFF -> IDLE.
    rst = 1'b1; on = 1'b1; start = 1'b0; in_sel = '0; num1 = '0; num2 = '0; op_sel = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset curr_state", curr_state, 2'b00);
    check("reset outputs", {out, out_hi, done, busy, err, carry, zero, ovf}, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post-reset curr_state", curr_state, 2'b01);
    check("idle next_state", next_state, 2'b01);
    check("idle outputs", {out, out_hi, done, busy, err, carry, zero, ovf}, '0);

    for (int i = 0; i < 22; i++) begin
      run_op(tbl[i].insel, tbl[i].n1, tbl[i].n2, tbl[i].op, lat);
      check($sformatf("row%0d latency", i), lat, tbl[i].lat);
      check($sformatf("row%0d out", i), out, tbl[i].eout);
      check($sformatf("row%0d out_hi", i), out_hi, tbl[i].ehi);
      check($sformatf("row%0d err", i), err, tbl[i].eerr);
      check($sformatf("row%0d carry", i), carry, tbl[i].ec);
      check($sformatf("row%0d zero", i), zero, tbl[i].ez);
      check($sformatf("row%0d ovf", i), ovf, tbl[i].ev);
    end
    m_out = tbl[21].eout; m_hi = tbl[21].ehi; m_err = tbl[21].eerr;
    m_c = tbl[21].ec; m_z = tbl[21].ez; m_v = tbl[21].ev;

    // MUL with a stray start mid-operation: ignored, busy held, no queued op.
    in_sel = 3'b010; num1 = 87; num2 = 26; op_sel = MUL; start = 1'b1;
    #1;
    check("mul next_state", next_state, 2'b11);
    @(posedge clk); #1;
    cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      check($sformatf("mul busy c%0d", cyc), busy, 1'b1);
      check($sformatf("mul done c%0d", cyc), done, 1'b0);
      start  = (cyc == 3);
      op_sel = (cyc == 3) ? ADD : MUL;
      @(posedge clk); #1;
      cyc++;
      seen = done;
    end
    start = 1'b0;
    check("mul done latency", cyc, W);
    check("mul out", out, 214);
    check("mul out_hi", out_hi, 8);
    check("mul ovf", ovf, 1'b1);
    @(posedge clk); #1;
    check("mul done pulse width", done, 1'b0);
    check("mul no queued start", curr_state, 2'b01);
    m_out = 214; m_hi = 8; m_err = 0; m_c = 0; m_z = 0; m_v = 1;

    for (int i = 0; i < 60; i++) begin
      s[2:1] = 2'($urandom);
      s[0]   = ($urandom_range(0, 7) == 0);
      rsel   = $urandom_range(0, 9);
      op     = (rsel < 7) ? 7'(1 << rsel) : 7'($urandom);
      model_op($sformatf("rand%0d", i), s, W'($urandom), W'($urandom), op);
    end

    // on dropped at MULT cycle 4: abort, hold results, no done.
    in_sel = 3'b010; num1 = 200; num2 = 3; op_sel = MUL; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    on = 1'b0;
    @(posedge clk); #1;
    check("abort curr_state", curr_state, 2'b00);
    check("abort busy", busy, 1'b0);
    check("abort out held", out, m_out);
    check("abort out_hi held", out_hi, m_hi);
    check("abort flags held", {err, carry, zero, ovf}, {m_err, m_c, m_z, m_v});
    seen = 0;
    repeat (10) begin
      seen |= done;
      @(posedge clk); #1;
    end
    check("abort no done", seen, 1'b0);
    on = 1'b1;
    @(posedge clk); #1;
    check("abort resume state", curr_state, 2'b01);
    model_op("after abort mul", 3'b010, 5, 7, MUL);
    model_op("after abort add", 3'b100, 0, 1, ADD);

    // rst at MULT cycle 4 clears everything.
    in_sel = 3'b010; num1 = 99; num2 = 99; op_sel = MUL; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst curr_state", curr_state, 2'b00);
    check("midrst outputs", {out, out_hi, done, busy, err, carry, zero, ovf}, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst resume state", curr_state, 2'b01);
    m_out = '0; m_hi = '0; m_err = 0; m_c = 0; m_z = 0; m_v = 0;
    model_op("after rst mul", 3'b010, 9, 9, MUL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
